// File: rtl/vldu_lane_feeder.sv
// vldu_lane_feeder: per-lane load writeback feeder.
// Accepts one load request at a time, slices the memory response stream into
// lane writeback beats (data, byte strobe, VRF address, id) through a small
// beat buffer, and pulses done back to the instruction launcher.
module vldu_lane_feeder #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned IdWidth   = 2,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // request from the instruction launcher
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AddrWidth-1:0]     req_addr_i,
  input  logic [LenWidth-1:0]      req_nbytes_i,
  input  logic [IdWidth-1:0]       req_id_i,
  // memory response beats
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [DataWidth-1:0]     mem_data_i,
  // lane load writeback
  output logic                     load_op_valid_o,
  input  logic                     load_op_gnt_i,
  output logic [DataWidth-1:0]     load_op_o,
  output logic [DataWidth/8-1:0]   load_op_strb_o,
  output logic [AddrWidth-1:0]     load_op_addr_o,
  output logic [IdWidth-1:0]       load_id_o,
  // completion
  output logic                     done_o,
  output logic [IdWidth-1:0]       done_id_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned PtrWidth  = $clog2(FifoDepth);
  localparam int unsigned CntWidth  = PtrWidth + 1;

  localparam logic [LenWidth-1:0] StrbLen = LenWidth'(StrbWidth);
  localparam logic [LenWidth-1:0] LenOne  = LenWidth'(1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(FifoDepth);
  localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  state_e state_q, state_d;

  // latched request
  logic [AddrWidth-1:0] base_q;
  logic [IdWidth-1:0]   id_q;
  logic [LenWidth-1:0]  nbeats_q;
  logic [LenWidth-1:0]  tail_q;

  // progress counters
  logic [LenWidth-1:0]  pushed_q;
  logic [LenWidth-1:0]  popped_q;

  // beat buffer
  logic [DataWidth-1:0] fifo_data_q [FifoDepth];
  logic [StrbWidth-1:0] fifo_strb_q [FifoDepth];
  logic [AddrWidth-1:0] fifo_addr_q [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q;
  logic [PtrWidth-1:0]  rd_ptr_q;
  logic [CntWidth-1:0]  count_q;

  // request decode
  logic [LenWidth-1:0]  req_quot;
  logic [LenWidth-1:0]  req_tail;
  logic [LenWidth-1:0]  req_nbeats;
  logic                 req_fire;

  // handshakes and beat attributes
  logic                 push;
  logic                 pop;
  logic                 last_push;
  logic                 last_pop;
  logic [AddrWidth-1:0] push_addr;
  logic [StrbWidth-1:0] push_strb;

  assign req_quot   = req_nbytes_i / StrbLen;
  assign req_tail   = req_nbytes_i % StrbLen;
  assign req_nbeats = req_quot + LenWidth'(req_tail != '0);
  assign req_fire   = req_valid_i && req_ready_o;

  // Memory ready only depends on registered state, so the lane grant never
  // reaches back into the memory handshake combinationally.
  assign mem_ready_o = (state_q == ACTIVE) && (pushed_q < nbeats_q) && (count_q < CntFull);

  assign push      = mem_valid_i && mem_ready_o;
  assign pop       = load_op_valid_o && load_op_gnt_i;
  assign last_push = (pushed_q == nbeats_q - LenOne);
  assign last_pop  = (popped_q == nbeats_q - LenOne);
  assign push_addr = base_q + AddrWidth'(pushed_q);

  // Only the final beat of a request with a partial word gets a short strobe.
  always_comb begin
    push_strb = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      push_strb[i] = !last_push || (tail_q == '0) || (LenWidth'(i) < tail_q);
    end
  end

  // Head of the buffer drives the lane; everything reads as zero when empty.
  always_comb begin
    load_op_valid_o = (count_q != '0);
    load_op_o       = '0;
    load_op_strb_o  = '0;
    load_op_addr_o  = '0;
    load_id_o       = '0;
    if (load_op_valid_o) begin
      load_op_o      = fifo_data_q[rd_ptr_q];
      load_op_strb_o = fifo_strb_q[rd_ptr_q];
      load_op_addr_o = fifo_addr_q[rd_ptr_q];
      load_id_o      = id_q;
    end
  end

  // Next-state and request/completion outputs of the control FSM.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    done_id_o   = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = (req_nbytes_i == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (pop && last_pop) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        done_id_o = id_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, request latches, counters and buffer pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      id_q     <= '0;
      nbeats_q <= '0;
      tail_q   <= '0;
      pushed_q <= '0;
      popped_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        base_q   <= req_addr_i;
        id_q     <= req_id_i;
        nbeats_q <= req_nbeats;
        tail_q   <= req_tail;
        pushed_q <= '0;
        popped_q <= '0;
      end
      if (push) begin
        pushed_q <= pushed_q + LenOne;
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        popped_q <= popped_q + LenOne;
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage; contents are never observed while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_data_i;
      fifo_strb_q[wr_ptr_q] <= push_strb;
      fifo_addr_q[wr_ptr_q] <= push_addr;
    end
  end

endmodule

// File: tb/tb_vldu_lane_feeder.sv
// tb_vldu_lane_feeder: directed, table-driven bench for vldu_lane_feeder.
module tb_vldu_lane_feeder;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_addr_i;
  logic [15:0] req_nbytes_i;
  logic [1:0]  req_id_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [63:0] mem_data_i;
  logic        load_op_valid_o;
  logic        load_op_gnt_i;
  logic [63:0] load_op_o;
  logic [7:0]  load_op_strb_o;
  logic [7:0]  load_op_addr_o;
  logic [1:0]  load_id_o;
  logic        done_o;
  logic [1:0]  done_id_o;

  int n_vectors;
  int n_miscompares;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] nbytes;
    logic [1:0]  id;
    int          gnt_delay;
    int          exp_beats;
    logic [7:0]  exp_last_strb;
  } vec_t;

  vec_t vecs [7];

  vldu_lane_feeder dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_nbytes_i    (req_nbytes_i),
    .req_id_i        (req_id_i),
    .mem_valid_i     (mem_valid_i),
    .mem_ready_o     (mem_ready_o),
    .mem_data_i      (mem_data_i),
    .load_op_valid_o (load_op_valid_o),
    .load_op_gnt_i   (load_op_gnt_i),
    .load_op_o       (load_op_o),
    .load_op_strb_o  (load_op_strb_o),
    .load_op_addr_o  (load_op_addr_o),
    .load_id_o       (load_id_o),
    .done_o          (done_o),
    .done_id_o       (done_id_o)
  );

  // free-running clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [63:0] beat_data(input logic [1:0] id, input logic [7:0] addr, input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(id) << 32) | (64'(addr) << 16) | 64'(k);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    checkOutput({tag, "_mem_ready"}, 64'(mem_ready_o), 64'd0);
    checkOutput({tag, "_valid"}, 64'(load_op_valid_o), 64'd0);
    checkOutput({tag, "_data"}, load_op_o, 64'd0);
    checkOutput({tag, "_strb"}, 64'(load_op_strb_o), 64'd0);
    checkOutput({tag, "_addr"}, 64'(load_op_addr_o), 64'd0);
    checkOutput({tag, "_load_id"}, 64'(load_id_o), 64'd0);
    checkOutput({tag, "_done"}, 64'(done_o), 64'd0);
    checkOutput({tag, "_done_id"}, 64'(done_id_o), 64'd0);
  endtask

  // Runs one request end to end against a small beat/occupancy model.
  task automatic applyStimulus(input vec_t v);
    int         mem_sent;
    int         rx;
    int         occ;
    int         last_gnt_cycle;
    bit         exp_done;
    bit         finished;
    logic [7:0] exp_addr;
    logic [7:0] exp_strb;

    req_valid_i   = 1'b1;
    req_addr_i    = v.addr;
    req_nbytes_i  = v.nbytes;
    req_id_i      = v.id;
    mem_valid_i   = 1'b1;
    mem_data_i    = 64'hDEAD_BEEF_DEAD_BEEF;
    load_op_gnt_i = 1'b0;
    checkOutput("idle_req_ready", 64'(req_ready_o), 64'd1);
    checkOutput("idle_mem_ready", 64'(mem_ready_o), 64'd0);
    nextCycle();
    req_valid_i = 1'b0;

    mem_sent       = 0;
    rx             = 0;
    last_gnt_cycle = -1;
    finished       = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      load_op_gnt_i = (cyc >= v.gnt_delay);
      mem_data_i    = beat_data(v.id, v.addr, mem_sent);
      occ           = mem_sent - rx;
      exp_done      = (v.exp_beats == 0) ? (cyc == 0)
                                         : (rx == v.exp_beats && last_gnt_cycle == cyc - 1);
      checkOutput("done", 64'(done_o), 64'(exp_done));
      checkOutput("req_ready_busy", 64'(req_ready_o), 64'd0);
      if (exp_done) begin
        checkOutput("done_id", 64'(done_id_o), 64'(v.id));
        checkOutput("done_mem_ready", 64'(mem_ready_o), 64'd0);
        checkOutput("done_valid", 64'(load_op_valid_o), 64'd0);
        finished = 1'b1;
      end else begin
        checkOutput("done_id_idle", 64'(done_id_o), 64'd0);
        checkOutput("mem_ready", 64'(mem_ready_o), 64'((mem_sent < v.exp_beats) && (occ < 2)));
        checkOutput("valid", 64'(load_op_valid_o), 64'(occ != 0));
        if (occ != 0) begin
          exp_addr = v.addr + 8'(rx);
          exp_strb = (rx == v.exp_beats - 1) ? v.exp_last_strb : 8'hFF;
          checkOutput("beat_data", load_op_o, beat_data(v.id, v.addr, rx));
          checkOutput("beat_addr", 64'(load_op_addr_o), 64'(exp_addr));
          checkOutput("beat_strb", 64'(load_op_strb_o), 64'(exp_strb));
          checkOutput("beat_id", 64'(load_id_o), 64'(v.id));
          if (load_op_gnt_i) begin
            rx++;
            last_gnt_cycle = cyc;
          end
        end else begin
          checkOutput("load_id_idle", 64'(load_id_o), 64'd0);
        end
        if (mem_ready_o && mem_valid_i && mem_sent < v.exp_beats) begin
          mem_sent++;
        end
        nextCycle();
      end
    end
    if (!finished) begin
      checkOutput("timeout_done", 64'(done_o), 64'd1);
    end

    mem_valid_i   = 1'b0;
    load_op_gnt_i = 1'b0;
    nextCycle();
    checkOutput("post_done_pulse", 64'(done_o), 64'd0);
    checkOutput("post_done_req_ready", 64'(req_ready_o), 64'd1);
  endtask

  // Hand-written sequence: reset in the middle of a four-beat request.
  task automatic midResetSequence();
    req_valid_i   = 1'b1;
    req_addr_i    = 8'h50;
    req_nbytes_i  = 16'd32;
    req_id_i      = 2'd2;
    mem_valid_i   = 1'b1;
    mem_data_i    = 64'h1111_0000_0000_0000;
    load_op_gnt_i = 1'b1;
    nextCycle();
    req_valid_i = 1'b0;
    checkOutput("rst_seq_mem_ready", 64'(mem_ready_o), 64'd1);
    nextCycle();
    mem_data_i = 64'h1111_0000_0000_0001;
    checkOutput("rst_seq_beat0_valid", 64'(load_op_valid_o), 64'd1);
    checkOutput("rst_seq_beat0_addr", 64'(load_op_addr_o), 64'h50);
    checkOutput("rst_seq_beat0_data", load_op_o, 64'h1111_0000_0000_0000);
    nextCycle();
    load_op_gnt_i = 1'b0;
    checkOutput("rst_seq_beat1_addr", 64'(load_op_addr_o), 64'h51);
    rst_i = 1'b1;
    nextCycle();
    rst_i       = 1'b0;
    mem_valid_i = 1'b0;
    checkResetValues("mid_reset");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("after_reset_done", 64'(done_o), 64'd0);
      checkOutput("after_reset_valid", 64'(load_op_valid_o), 64'd0);
    end
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;

    vecs[0] = '{addr: 8'h10, nbytes: 16'd24, id: 2'd1, gnt_delay: 0, exp_beats: 3, exp_last_strb: 8'hFF};
    vecs[1] = '{addr: 8'h20, nbytes: 16'd13, id: 2'd2, gnt_delay: 0, exp_beats: 2, exp_last_strb: 8'h1F};
    vecs[2] = '{addr: 8'h40, nbytes: 16'd32, id: 2'd0, gnt_delay: 5, exp_beats: 4, exp_last_strb: 8'hFF};
    vecs[3] = '{addr: 8'hFF, nbytes: 16'd16, id: 2'd2, gnt_delay: 0, exp_beats: 2, exp_last_strb: 8'hFF};
    vecs[4] = '{addr: 8'h33, nbytes: 16'd0,  id: 2'd3, gnt_delay: 0, exp_beats: 0, exp_last_strb: 8'h00};
    vecs[5] = '{addr: 8'h80, nbytes: 16'd1,  id: 2'd1, gnt_delay: 0, exp_beats: 1, exp_last_strb: 8'h01};
    vecs[6] = '{addr: 8'h05, nbytes: 16'd9,  id: 2'd3, gnt_delay: 2, exp_beats: 2, exp_last_strb: 8'h01};

    rst_i         = 1'b1;
    req_valid_i   = 1'b0;
    req_addr_i    = '0;
    req_nbytes_i  = '0;
    req_id_i      = '0;
    mem_valid_i   = 1'b0;
    mem_data_i    = '0;
    load_op_gnt_i = 1'b0;
    nextCycle();
    nextCycle();
    checkResetValues("reset");
    rst_i = 1'b0;
    nextCycle();

    for (int i = 0; i < 7; i++) begin
      $display("[TB] request %0d: addr=%0h nbytes=%0d id=%0d", i, vecs[i].addr, vecs[i].nbytes, vecs[i].id);
      applyStimulus(vecs[i]);
    end

    $display("[TB] mid-operation reset sequence");
    midResetSequence();
    applyStimulus(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
